// File: rtl/pow5_bcd_converter.sv
// pow5_bcd_converter: iterative double-dabble binary-to-BCD converter
// with a one-entry pending buffer and a saturating drop counter.
module pow5_bcd_converter #(
    parameter int w_in     = 40,
    parameter int n_digits = 13,
    parameter int w_digit  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [w_in-1:0]         in_data,
    output logic [4*n_digits-1:0]   bcd,
    output logic                    out_valid,
    output logic                    overflow,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int w_cnt = $clog2(w_in + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [4*n_digits-1:0]   acc;
    logic [4*n_digits-1:0]   acc_adj;
    logic [w_in-1:0]         opnd;
    logic [w_cnt-1:0]        bit_cnt;
    logic                    cnt_last;
    logic                    pend_valid;
    logic [w_in-1:0]         pend_data;
    logic                    start_pend;
    logic                    start_in;
    logic                    pend_wr;
    logic                    pend_drop;
    logic                    shift_en;
    logic                    finish;

    assign cnt_last = (bit_cnt == w_cnt'(w_in));
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt  = state;
        start_pend = 1'b0;
        start_in   = 1'b0;
        pend_wr    = 1'b0;
        pend_drop  = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    start_in  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_last) begin
                    state_nxt = DONE;
                end else begin
                    shift_en = 1'b1;
                end
                pend_wr   = in_valid;
                pend_drop = in_valid & pend_valid;
            end
            DONE: begin
                finish = 1'b1;
                if (pend_valid) begin
                    start_pend = 1'b1;
                    pend_wr    = in_valid;
                    state_nxt  = SHIFT;
                end else if (in_valid) begin
                    start_in  = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction on every digit >= 5, each digit independent
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < n_digits; i++) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] +
                ((acc[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    // Conversion engine: load operand, then shift one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            opnd    <= '0;
            bit_cnt <= '0;
        end else if (start_pend) begin
            acc     <= '0;
            opnd    <= pend_data;
            bit_cnt <= '0;
        end else if (start_in) begin
            acc     <= '0;
            opnd    <= in_data;
            bit_cnt <= '0;
        end else if (shift_en) begin
            acc     <= {acc_adj[4*n_digits-2:0], opnd[w_in-1]};
            opnd    <= {opnd[w_in-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Result registers, updated only when leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= finish;
            if (finish) begin
                bcd      <= acc;
                overflow <= |acc[4*n_digits-1:4*w_digit];
            end
        end
    end

    // Pending slot: latest arrival wins while a conversion is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (pend_wr) begin
            pend_valid <= 1'b1;
            pend_data  <= in_data;
        end else if (start_pend) begin
            pend_valid <= 1'b0;
        end
    end

    // Count overwritten pending operands, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (pend_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pow5_bcd_converter.sv
// tb_pow5_bcd_converter: directed vector table plus hand-written
// sequences for pending buffer, DONE-cycle restart and mid-run reset.
module tb_pow5_bcd_converter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [39:0]   in_data;
    logic [51:0]   bcd;
    logic          out_valid;
    logic          overflow;
    logic          busy;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [39:0] din;
        logic [51:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    pow5_bcd_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .bcd       (bcd),
        .out_valid (out_valid),
        .overflow  (overflow),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait up to lim edges for out_valid; returns cycle stamp of the edge
    task automatic wait_ov(input int lim, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < lim; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    // Issue one in_valid pulse; returns the cycle stamp of its capture edge
    task automatic pulse(input logic [39:0] d, output int t);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        t        = cyc;
        in_valid = 1'b0;
    endtask

    initial begin
        int   t0, t1, t2, npulse;
        logic ok;

        vecs[0] = '{40'd243,           52'h0000000000243, 1'b0};
        vecs[1] = '{40'd1078203909375, 52'h1078203909375, 1'b1};
        vecs[2] = '{40'd0,             52'h0000000000000, 1'b0};
        vecs[3] = '{40'd99999999,      52'h0000099999999, 1'b0};
        vecs[4] = '{40'd100000000,     52'h0000100000000, 1'b1};
        vecs[5] = '{40'd1099511627775, 52'h1099511627775, 1'b1};
        vecs[6] = '{40'd7776,          52'h0000000007776, 1'b0};
        vecs[7] = '{40'd59049,         52'h0000000059049, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].din, t0);
            chk("busy_run", 64'(busy), 64'd1);
            wait_ov(100, t1, ok);
            chk("timeout", 64'(ok), 64'd1);
            chk("latency", 64'(t1 - t0), 64'd42);
            chk("bcd", 64'(bcd), 64'(vecs[i].exp_bcd));
            chk("ovf", 64'(overflow), 64'(vecs[i].exp_ovf));
            chk("busy_end", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            chk("ov_pulse", 64'(out_valid), 64'd0);
            chk("bcd_hold", 64'(bcd), 64'(vecs[i].exp_bcd));
            if (i == 1) chk("low8", 64'(bcd[31:0]), 64'h03909375);
            if (i == 4) chk("dig8", 64'(bcd[35:32]), 64'd1);
        end

        // Three back-to-back arrivals: middle one is overwritten
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 40'd32;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        in_data = 40'd243;
        @(negedge clk);
        in_data = 40'd1024;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(100, t1, ok);
        chk("b2b_to1", 64'(ok), 64'd1);
        chk("b2b_lat1", 64'(t1 - t0), 64'd42);
        chk("b2b_bcd1", 64'(bcd), 64'h32);
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_ov(100, t2, ok);
        chk("b2b_to2", 64'(ok), 64'd1);
        chk("b2b_gap", 64'(t2 - t1), 64'd42);
        chk("b2b_bcd2", 64'(bcd), 64'h1024);
        chk("b2b_drop", 64'(drop_cnt), 64'd1);
        npulse = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) npulse++;
        end
        chk("b2b_extra", 64'(npulse), 64'd0);
        chk("b2b_idle", 64'(busy), 64'd0);

        // Arrival exactly in the DONE cycle restarts without IDLE
        pulse(40'd243, t0);
        repeat (41) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 40'd7776;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t1 = cyc;
        chk("done_ov", 64'(out_valid), 64'd1);
        chk("done_lat", 64'(t1 - t0), 64'd42);
        chk("done_bcd", 64'(bcd), 64'h243);
        chk("done_busy", 64'(busy), 64'd1);
        wait_ov(100, t2, ok);
        chk("done_to", 64'(ok), 64'd1);
        chk("done_gap", 64'(t2 - t1), 64'd42);
        chk("done_bcd2", 64'(bcd), 64'h7776);
        chk("done_drop", 64'(drop_cnt), 64'd1);

        // Reset mid-conversion with pending slot full
        pulse(40'd1024, t0);
        pulse(40'd5, t1);
        pulse(40'd6, t2);
        chk("pre_drop", 64'(drop_cnt), 64'd2);
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_bcd", 64'(bcd), 64'd0);
        chk("mr_ov", 64'(out_valid), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_drop", 64'(drop_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) npulse++;
        end
        chk("mr_stale", 64'(npulse), 64'd0);
        chk("mr_idle", 64'(busy), 64'd0);
        pulse(40'd7776, t0);
        wait_ov(100, t1, ok);
        chk("mr_to", 64'(ok), 64'd1);
        chk("mr_lat", 64'(t1 - t0), 64'd42);
        chk("mr_bcd2", 64'(bcd), 64'h7776);
        chk("mr_ovf2", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
